// File: rtl/fir_sample_serializer_if.sv
// Parallel sample handshake between the FIR filter output and the serializer.
// The filter is the master; it cannot stall, so ready is advisory only.
interface fir_sample_serializer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] sample_in;
    logic                  sample_valid;
    logic                  sample_ready;

    modport master (
        output sample_in,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/fir_sample_serializer.sv
// Scales accepted FIR samples and shifts them out MSB-first on sclk/sdata/fsync,
// with a one-word holding register and a saturating count of refused samples.
module fir_sample_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 2,
    parameter int SCALE      = 0,
    parameter int DROP_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    fir_sample_serializer_if.slave  samples,
    output logic                    sclk,
    output logic                    sdata,
    output logic                    fsync,
    output logic                    busy,
    output logic                    sample_drop,
    output logic [DROP_CNT_W-1:0]   drop_count
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] hold;
    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DIV_W-1:0]      div_cnt;
    logic                  phase_high;

    logic accept;
    logic refuse;
    logic div_wrap;
    logic load;
    logic shift;

    assign samples.sample_ready = !hold_valid;
    assign accept   = samples.sample_valid && !hold_valid;
    assign refuse   = samples.sample_valid && hold_valid;
    assign div_wrap = (div_cnt == DIV_LAST);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (hold_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (phase_high && div_wrap) begin
                    if (bit_cnt != '0) begin
                        shift = 1'b1;
                    end else if (hold_valid) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid  <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            phase_high  <= 1'b0;
            sample_drop <= 1'b0;
            drop_count  <= '0;
        end else begin
            sample_drop <= refuse;
            if (refuse && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end

            if (accept) begin
                hold_valid <= 1'b1;
            end else if (load) begin
                hold_valid <= 1'b0;
            end

            // A load restarts the bit timing, whether from IDLE or back-to-back.
            if (load) begin
                shreg      <= hold;
                bit_cnt    <= BIT_LAST;
                div_cnt    <= '0;
                phase_high <= 1'b0;
            end else if (state == SHIFT) begin
                if (div_wrap) begin
                    div_cnt    <= '0;
                    phase_high <= !phase_high;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
                if (shift) begin
                    shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt - 1'b1;
                end
            end
        end
    end

    // NOTE: hold data needs no reset; it is only ever consumed while hold_valid is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold <= $signed(samples.sample_in) >>> SCALE;
        end
    end

    assign busy  = (state == SHIFT);
    assign sclk  = busy && phase_high;
    assign sdata = busy && shreg[DATA_WIDTH-1];
    assign fsync = busy && (bit_cnt == BIT_LAST);

endmodule

// File: tb/tb_fir_sample_serializer.sv
// Directed bench for fir_sample_serializer: a time-elapsed word model checked every
// cycle, a serial receiver, and literal expectations on recovered words and counters.
module tb_fir_sample_serializer;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Instance A: CLK_DIV=2, no scaling, 16-bit drop counter.
    // Instance B: CLK_DIV=1, SCALE=4, 2-bit drop counter so saturation is reachable quickly.
    fir_sample_serializer_if #(.DATA_WIDTH(DW)) a_if();
    fir_sample_serializer_if #(.DATA_WIDTH(DW)) b_if();

    logic        a_sclk, a_sdata, a_fsync, a_busy, a_drop;
    logic [15:0] a_cnt;
    logic        b_sclk, b_sdata, b_fsync, b_busy, b_drop;
    logic [1:0]  b_cnt;

    fir_sample_serializer #(
        .DATA_WIDTH(DW), .CLK_DIV(2), .SCALE(0), .DROP_CNT_W(16)
    ) dut_a (
        .clk(clk), .reset(reset), .samples(a_if.slave),
        .sclk(a_sclk), .sdata(a_sdata), .fsync(a_fsync), .busy(a_busy),
        .sample_drop(a_drop), .drop_count(a_cnt)
    );

    fir_sample_serializer #(
        .DATA_WIDTH(DW), .CLK_DIV(1), .SCALE(4), .DROP_CNT_W(2)
    ) dut_b (
        .clk(clk), .reset(reset), .samples(b_if.slave),
        .sclk(b_sclk), .sdata(b_sdata), .fsync(b_fsync), .busy(b_busy),
        .sample_drop(b_drop), .drop_count(b_cnt)
    );

    function automatic int div_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int scale_of(input int k);
        return (k == 0) ? 0 : 4;
    endfunction

    function automatic int cnt_max(input int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    // Model: a word in flight is described only by its value and clocks elapsed since load.
    logic        m_active [2];
    int          m_t      [2];
    logic [31:0] m_word   [2];
    logic [31:0] m_hold   [2];
    logic        m_hold_v [2];
    logic        m_drop   [2];
    int          m_cnt    [2];
    logic        started = 1'b0;

    task automatic model_step(input int k, input logic rst_i, input logic v, input logic [31:0] d);
        logic              acc;
        logic              ref_s;
        logic signed [31:0] s;
        int                c;
        c = div_of(k);
        if (rst_i) begin
            m_active[k] = 1'b0;
            m_t[k]      = 0;
            m_hold_v[k] = 1'b0;
            m_drop[k]   = 1'b0;
            m_cnt[k]    = 0;
        end else begin
            acc   = v && !m_hold_v[k];
            ref_s = v && m_hold_v[k];
            m_drop[k] = ref_s;
            if (ref_s && (m_cnt[k] < cnt_max(k))) m_cnt[k]++;
            if (m_active[k]) begin
                m_t[k]++;
                if (m_t[k] == 2 * c * DW) begin
                    m_t[k] = 0;
                    if (m_hold_v[k]) begin
                        m_word[k]   = m_hold[k];
                        m_hold_v[k] = 1'b0;
                    end else begin
                        m_active[k] = 1'b0;
                    end
                end
            end else if (m_hold_v[k]) begin
                m_word[k]   = m_hold[k];
                m_hold_v[k] = 1'b0;
                m_active[k] = 1'b1;
                m_t[k]      = 0;
            end
            if (acc) begin
                s           = $signed(d);
                m_hold[k]   = s >>> scale_of(k);
                m_hold_v[k] = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        model_step(0, reset, a_if.sample_valid, a_if.sample_in);
        model_step(1, reset, b_if.sample_valid, b_if.sample_in);
        if (reset) started = 1'b1;
    end

    // {ready, busy, sclk, sdata, fsync, drop, drop_count[15:0]}
    function automatic logic [21:0] exp_vec(input int k);
        logic [21:0] v;
        int          b;
        int          ph;
        v     = '0;
        v[21] = !m_hold_v[k];
        v[20] = m_active[k];
        if (m_active[k]) begin
            b     = m_t[k] / (2 * div_of(k));
            ph    = m_t[k] % (2 * div_of(k));
            v[19] = (ph >= div_of(k));
            v[18] = m_word[k][DW-1-b];
            v[17] = (b == 0);
        end
        v[16]    = m_drop[k];
        v[15:0]  = m_cnt[k][15:0];
        return v;
    endfunction

    // Serial receiver and event counters, sampled on the falling edge.
    logic [31:0] rx_a[$];
    logic [31:0] rx_b[$];
    logic [31:0] rxa_w = '0, rxb_w = '0;
    int          rxa_n = 0, rxb_n = 0;
    logic        rxa_prev = 1'b0, rxb_prev = 1'b0, fsa_prev = 1'b0;
    int          fs_cycles_a = 0, busy_cycles_a = 0, drops_a = 0, drops_b = 0;
    int          fs_rise_prev = 0, fs_rise_last = 0;

    always @(negedge clk) begin
        if (a_fsync === 1'b1) fs_cycles_a++;
        if (a_busy === 1'b1) busy_cycles_a++;
        if (a_drop === 1'b1) drops_a++;
        if (b_drop === 1'b1) drops_b++;
        if ((a_fsync === 1'b1) && !fsa_prev) begin
            fs_rise_prev = fs_rise_last;
            fs_rise_last = cyc;
        end
        fsa_prev = (a_fsync === 1'b1);

        if ((a_sclk === 1'b1) && !rxa_prev) begin
            if (a_fsync === 1'b1) begin
                rxa_w = {31'b0, a_sdata};
                rxa_n = 1;
            end else begin
                rxa_w = {rxa_w[30:0], a_sdata};
                rxa_n++;
            end
            if (rxa_n == DW) rx_a.push_back(rxa_w);
        end
        rxa_prev = (a_sclk === 1'b1);

        if ((b_sclk === 1'b1) && !rxb_prev) begin
            if (b_fsync === 1'b1) begin
                rxb_w = {31'b0, b_sdata};
                rxb_n = 1;
            end else begin
                rxb_w = {rxb_w[30:0], b_sdata};
                rxb_n++;
            end
            if (rxb_n == DW) rx_b.push_back(rxb_w);
        end
        rxb_prev = (b_sclk === 1'b1);
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        if (started) begin
            check("cycle_a", {a_if.sample_ready, a_busy, a_sclk, a_sdata, a_fsync, a_drop, a_cnt}, exp_vec(0));
            check("cycle_b", {b_if.sample_ready, b_busy, b_sclk, b_sdata, b_fsync, b_drop, 14'b0, b_cnt}, exp_vec(1));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic v, input logic [31:0] d);
        if (k == 0) begin
            a_if.sample_valid = v;
            a_if.sample_in    = d;
        end else begin
            b_if.sample_valid = v;
            b_if.sample_in    = d;
        end
    endtask

    task automatic offer(input int k, input logic [31:0] d);
        drive(k, 1'b1, d);
        tick();
        drive(k, 1'b0, 32'h0);
    endtask

    task automatic check_rx(input string name, input int k, input int idx, input logic [31:0] exp);
        logic [31:0] got;
        got = 'x;
        if (k == 0 && idx < rx_a.size()) got = rx_a[idx];
        if (k == 1 && idx < rx_b.size()) got = rx_b[idx];
        check(name, got, exp);
    endtask

    int base_fs, base_busy, base_drop;

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 32'h0);
        drive(1, 1'b0, 32'h0);
        repeat (3) tick();
        reset = 1'b0;

        check("reset_ready", a_if.sample_ready, 1);
        check("reset_serial", {a_sclk, a_sdata, a_fsync, a_busy}, 0);
        check("reset_drop_count", a_cnt, 0);

        // Single word from idle.
        base_fs   = fs_cycles_a;
        base_busy = busy_cycles_a;
        offer(0, 32'hA500_0001);
        repeat (140) tick();
        check("single_fsync_clocks", fs_cycles_a - base_fs, 4);
        check("single_busy_clocks", busy_cycles_a - base_busy, 128);
        check_rx("single_word", 0, 0, 32'hA500_0001);
        check("single_idle_after", {a_sclk, a_sdata, a_fsync, a_busy}, 0);

        // Back-to-back: second word queued 20 clocks after the first.
        offer(0, 32'h1234_5678);
        repeat (19) tick();
        offer(0, 32'hFFFF_FFFF);
        repeat (300) tick();
        check("b2b_fsync_spacing", fs_rise_last - fs_rise_prev, 128);
        check_rx("b2b_word0", 0, 1, 32'h1234_5678);
        check_rx("b2b_word1", 0, 2, 32'hFFFF_FFFF);

        // Three samples on consecutive cycles during a word: one queued, two dropped.
        offer(0, 32'h1111_1111);
        repeat (5) tick();
        base_drop = drops_a;
        drive(0, 1'b1, 32'h0000_0001); tick();
        drive(0, 1'b1, 32'h0000_0002); tick();
        drive(0, 1'b1, 32'h0000_0003); tick();
        drive(0, 1'b0, 32'h0);
        repeat (2) tick();
        check("drop_pulses", drops_a - base_drop, 2);
        check("drop_count_two", a_cnt, 2);
        repeat (300) tick();
        check_rx("drop_word0", 0, 3, 32'h1111_1111);
        check_rx("drop_word1", 0, 4, 32'h0000_0001);
        check("drop_word_total", rx_a.size(), 5);

        // Scaling on B (SCALE=4, CLK_DIV=1).
        offer(1, 32'hFFFF_FF00);
        repeat (80) tick();
        offer(1, 32'h0000_0100);
        repeat (80) tick();
        check_rx("scale_neg", 1, 0, 32'hFFFF_FFF0);
        check_rx("scale_pos", 1, 1, 32'h0000_0010);

        // Saturation on B's 2-bit counter: 2 refusals, then 3 more.
        offer(1, 32'h0000_0070);
        repeat (3) tick();
        base_drop = drops_b;
        drive(1, 1'b1, 32'h0000_0100); tick();
        drive(1, 1'b1, 32'h0000_0200); tick();
        drive(1, 1'b1, 32'h0000_0300); tick();
        drive(1, 1'b0, 32'h0);
        tick();
        check("sat_count_two", b_cnt, 2);
        drive(1, 1'b1, 32'h0000_0400); tick();
        drive(1, 1'b1, 32'h0000_0500); tick();
        drive(1, 1'b1, 32'h0000_0600); tick();
        drive(1, 1'b0, 32'h0);
        tick();
        check("sat_count_max", b_cnt, 3);
        check("sat_pulses", drops_b - base_drop, 5);
        repeat (150) tick();
        check_rx("sat_word0", 1, 2, 32'h0000_0007);
        check_rx("sat_word1", 1, 3, 32'h0000_0010);
        check("sat_word_total", rx_b.size(), 4);

        // Reset mid-word (around bit 10 of 0xDEADBEEF), then a clean word.
        offer(0, 32'hDEAD_BEEF);
        repeat (42) tick();
        check("abort_in_flight", a_busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_serial", {a_sclk, a_sdata, a_fsync, a_busy}, 0);
        check("abort_ready", a_if.sample_ready, 1);
        check("abort_drop_count", a_cnt, 0);
        offer(0, 32'h0000_000F);
        repeat (140) tick();
        check_rx("after_abort_word", 0, 5, 32'h0000_000F);
        check("after_abort_total", rx_a.size(), 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_sample_serializer.md
Name: fir_sample_serializer

Overview:
Transmit side of the filter output path. Accepts parallel output samples from the direct-form FIR filter through a valid/ready interface. Applies the configured arithmetic down-scale, then shifts each sample out MSB-first on a serial link (sclk/sdata/fsync) toward an external DAC or link receiver. A one-word holding register lets the next sample queue during transmission. Samples arriving when the holding register is full are dropped and counted, because the upstream filter cannot stall.

Parameters:
DATA_WIDTH, 32, sample width in bits (>=2)
CLK_DIV, 2, system clocks per sclk half-period (>=1); one bit period = 2*CLK_DIV clocks
SCALE, 0, arithmetic right shift applied to the sample at acceptance (0..DATA_WIDTH-1)
DROP_CNT_W, 16, width of the saturating drop counter

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
sample_in  input  DATA_WIDTH  signed sample (FIR output_signal_y)
sample_valid  input  1  sample_in valid this cycle
sample_ready  output  1  holding register empty; sample accepted when valid && ready
sclk  output  1  serial bit clock; receiver samples sdata on rising edge
sdata  output  1  serial data, MSB first
fsync  output  1  high for the whole bit period of each word's MSB
busy  output  1  word in flight (state SHIFT)
sample_drop  output  1  one-cycle pulse, the cycle after a sample was refused
drop_count  output  DROP_CNT_W  saturating count of refused samples

Behaviour:
- Reset, taking effect at the next edge and including mid-word:
  - state=IDLE, hold_valid=0, shift register=0, counters=0, drop_count=0.
  - sclk=0, sdata=0, fsync=0, busy=0, sample_drop=0, sample_ready=1.
  - An in-flight word is aborted with no partial completion.
- Handshake:
  - sample_ready = !hold_valid (combinational from the register).
  - On edge with sample_valid && sample_ready: hold <= sample_in >>> SCALE (sign-extended), hold_valid<=1.
- Drop:
  - sample_valid && !sample_ready at an edge -> sample_drop=1 for the following cycle.
  - On the same edge, drop_count increments, saturating at all-ones.
- FSM, states IDLE and SHIFT.
- IDLE:
  - sclk=0, sdata=0, fsync=0.
  - If hold_valid: at that edge, load shift register from hold, hold_valid<=0, bit_cnt<=DATA_WIDTH-1, div_cnt<=0, phase<=low, goto SHIFT.
- SHIFT:
  - sdata = shift register MSB; fsync = (bit_cnt==DATA_WIDTH-1).
  - sclk low for CLK_DIV clocks, then high for CLK_DIV clocks. Data is stable across the rising edge.
  - At the end of the high phase:
    - bit_cnt!=0: shift left 1, bit_cnt--.
    - bit_cnt==0 and hold_valid: reload from hold immediately. This is back-to-back with no gap, sclk returns low, and fsync reasserts.
    - bit_cnt==0 and no hold: goto IDLE.
- Latency:
  - Sample accepted at edge E0 with the FSM idle -> loaded at E1.
  - sdata/fsync valid from E1; first sclk rise at E1+CLK_DIV.
  - Word occupies exactly 2*CLK_DIV*DATA_WIDTH clocks.
- Simultaneous events:
  - The hold-to-shift transfer and a new acceptance cannot coincide, because ready is low while hold is full.
  - After the transfer edge, ready is 1 the next cycle.
- CLK_DIV=1 is legal: sclk toggles every clock (clk/2).
- Sustained input faster than one word per 2*CLK_DIV*DATA_WIDTH clocks: every sample refused while hold is full is dropped and counted. Accepted samples are never lost or reordered.

Test Plan:
1. Reset (DATA_WIDTH=32, CLK_DIV=2) -> sample_ready=1, sclk/sdata/fsync/busy=0, drop_count=0.
2. Single word 0xA5000001 in idle:
   - fsync high for the first 4 clocks.
   - 32 sclk rising edges capture bits 1010_0101_0000...0001.
   - busy low and outputs 0 after exactly 128 clocks.
3. 0x12345678, then 0xFFFFFFFF offered 20 clocks later:
   - Second word accepted (ready drops for 1 word).
   - Second word's fsync rises exactly 128 clocks after the first's, with no idle sclk gap.
   - Receiver recovers both words in order.
4. Three samples on consecutive cycles while a word is in flight:
   - First fills hold.
   - Next two are refused: sample_drop pulses twice, drop_count=2.
   - Preload drop_count=0xFFFE and refuse 3 more -> saturates at 0xFFFF.
5. SCALE=4, sample_in=0xFFFFFF00 (-256) -> transmitted 0xFFFFFFF0 (-16); sample_in=0x00000100 -> 0x00000010.
6. Reset asserted for one cycle during bit 10 of 0xDEADBEEF:
   - Next cycle sclk/sdata/fsync/busy=0, ready=1.
   - A following word 0x0000000F transmits cleanly with fsync on its MSB and no residual bits.
